// File: rtl/sram_pixel_server_pkg.sv
// Shared definitions for the SRAM pixel server.
// Holds the frame geometry, the RGB565 field positions, the pixel-word width,
// and the address helpers that turn an (x, y) coordinate into a linear SRAM
// word address. The address is built from shifts and adds with no divider.
package sram_pixel_server_pkg;

   localparam int COORD_W = 10;
   localparam int PIX_W   = 16;
   // 307199 is the largest in-frame address, so 19 bits hold it
   localparam int LIN_W   = 19;

   localparam logic [COORD_W-1:0] H_RES = 10'd640;
   localparam logic [COORD_W-1:0] V_RES = 10'd480;

   localparam int R_MSB = 15;
   localparam int R_LSB = 11;
   localparam int G_MSB = 10;
   localparam int G_LSB = 5;
   localparam int B_MSB = 4;
   localparam int B_LSB = 0;

   function automatic logic inRange(input logic [COORD_W-1:0] x,
                                    input logic [COORD_W-1:0] y);
      return (x < H_RES) && (y < V_RES);
   endfunction

   // y*640 + x == (y<<9) + (y<<7) + x
   function automatic logic [LIN_W-1:0] pixAddr(input logic [COORD_W-1:0] x,
                                                input logic [COORD_W-1:0] y);
      logic [LIN_W-1:0] yy;
      yy = LIN_W'(y);
      return (yy << 9) + (yy << 7) + LIN_W'(x);
   endfunction

endpackage

// File: rtl/sram_pixel_server_fifo.sv
// pixel_wr_fifo: small write buffer between the camera-side write port and
// the SRAM drain. Entries are {word address, RGB565 data}.
// Ports:
//   iCLK, iRST_N   clock, asynchronous active-low reset (empties the FIFO)
//   iPUSH, iDATA   store one entry (caller never pushes a full FIFO without
//                  a pop in the same cycle)
//   iPOP           retire the head entry (caller never pops when empty)
//   oHEAD          head entry, read straight from the storage registers
//   oFULL, oEMPTY  occupancy flags derived from the registered count
//   oCOUNT         current number of entries
module pixel_wr_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 36
) (
   input  logic                     iCLK,
   input  logic                     iRST_N,
   input  logic                     iPUSH,
   input  logic                     iPOP,
   input  logic [WIDTH-1:0]         iDATA,
   output logic [WIDTH-1:0]         oHEAD,
   output logic                     oFULL,
   output logic                     oEMPTY,
   output logic [$clog2(DEPTH):0]   oCOUNT
);

   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wrPtr;
   logic [PW-1:0]    rdPtr;
   logic [PW:0]      count;

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         // pointers wrap naturally since DEPTH is a power of two
         if (iPUSH) wrPtr <= wrPtr + PW'(1);
         if (iPOP)  rdPtr <= rdPtr + PW'(1);
         case ({iPUSH, iPOP})
            2'b10:   count <= count + (PW+1)'(1);
            2'b01:   count <= count - (PW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // storage needs no reset: the pointers define which entries are live
   always_ff @(posedge iCLK) begin
      if (iPUSH) mem[wrPtr] <= iDATA;
   end

   assign oHEAD  = mem[rdPtr];
   assign oFULL  = (count == (PW+1)'(DEPTH));
   assign oEMPTY = (count == '0);
   assign oCOUNT = count;

endmodule

// File: rtl/sram_pixel_server.sv
// sram_pixel_server: single-port SRAM frame-buffer server.
// Answers one-cycle pixel read requests with an RGB565 pixel one cycle later,
// and drains buffered camera writes into the SRAM in cycles without an
// in-range read. Reads always win the bus.
// Ports:
//   iCLK, iRST_N            clock, asynchronous active-low reset
//   iREQ, iX, iY            read request and coordinate
//   oR, oG, oB, oREADY      captured pixel and one-cycle valid pulse
//   iWR_REQ, iWR_X, iWR_Y,
//   iWR_DATA                camera write request, coordinate and RGB565 word
//   oWR_FULL, oWR_DROP      buffer full flag, rejected-write pulse
//   oSRAM_*, ioSRAM_DQ      asynchronous SRAM address, strobes and data bus
module sram_pixel_server
   import sram_pixel_server_pkg::*;
#(
   parameter int ADDR_W     = 20,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                iCLK,
   input  logic                iRST_N,
   input  logic                iREQ,
   input  logic [COORD_W-1:0]  iX,
   input  logic [COORD_W-1:0]  iY,
   output logic [4:0]          oR,
   output logic [5:0]          oG,
   output logic [4:0]          oB,
   output logic                oREADY,
   input  logic                iWR_REQ,
   input  logic [COORD_W-1:0]  iWR_X,
   input  logic [COORD_W-1:0]  iWR_Y,
   input  logic [PIX_W-1:0]    iWR_DATA,
   output logic                oWR_FULL,
   output logic                oWR_DROP,
   output logic [ADDR_W-1:0]   oSRAM_ADDR,
   inout  wire  [PIX_W-1:0]    ioSRAM_DQ,
   output logic                oSRAM_CE_N,
   output logic                oSRAM_OE_N,
   output logic                oSRAM_WE_N,
   output logic                oSRAM_UB_N,
   output logic                oSRAM_LB_N
);

   localparam int ENT_W = ADDR_W + PIX_W;
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   logic              rdHit;
   logic              wrInRange;
   logic              fifoPush;
   logic              fifoPop;
   logic              fifoFull;
   logic              fifoEmpty;
   logic [CNT_W-1:0]  fifoCount;
   logic [ENT_W-1:0]  fifoHead;
   logic [ADDR_W-1:0] rdAddr;
   logic [ADDR_W-1:0] wrAddr;
   logic [ADDR_W-1:0] headAddr;
   logic [PIX_W-1:0]  headData;
   logic              dqOe;
   logic              dropNext;

   assign rdAddr = ADDR_W'(pixAddr(iX, iY));
   assign wrAddr = ADDR_W'(pixAddr(iWR_X, iWR_Y));

   assign rdHit     = iREQ & inRange(iX, iY);
   // an out-of-range read leaves the bus free for the drain
   assign fifoPop   = ~fifoEmpty & ~rdHit;
   // out-of-range writes vanish here: no entry, no drop pulse
   assign wrInRange = iWR_REQ & inRange(iWR_X, iWR_Y);
   // a pop in the same cycle frees a slot, so a full FIFO still accepts
   assign fifoPush  = wrInRange & ((fifoCount < CNT_W'(FIFO_DEPTH)) | fifoPop);
   assign dropNext  = wrInRange & ~fifoPush;

   assign {headAddr, headData} = fifoHead;

   pixel_wr_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (ENT_W)
   ) uWrFifo (
      .iCLK   (iCLK),
      .iRST_N (iRST_N),
      .iPUSH  (fifoPush),
      .iPOP   (fifoPop),
      .iDATA  ({wrAddr, iWR_DATA}),
      .oHEAD  (fifoHead),
      .oFULL  (fifoFull),
      .oEMPTY (fifoEmpty),
      .oCOUNT (fifoCount)
   );

   // Bus mux is gated by reset directly so strobes release the instant reset
   // asserts, even mid-write.
   always_comb begin
      oSRAM_ADDR = '0;
      oSRAM_OE_N = 1'b1;
      oSRAM_WE_N = 1'b1;
      dqOe       = 1'b0;
      if (iRST_N) begin
         if (rdHit) begin
            oSRAM_ADDR = rdAddr;
            oSRAM_OE_N = 1'b0;
         end else if (fifoPop) begin
            oSRAM_ADDR = headAddr;
            oSRAM_WE_N = 1'b0;
            dqOe       = 1'b1;
         end
      end
   end

   assign oSRAM_CE_N = ~iRST_N;
   assign oSRAM_UB_N = 1'b0;
   assign oSRAM_LB_N = 1'b0;

   assign ioSRAM_DQ = dqOe ? headData : 'z;

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         oR       <= '0;
         oG       <= '0;
         oB       <= '0;
         oREADY   <= 1'b0;
         oWR_DROP <= 1'b0;
      end else begin
         oREADY   <= iREQ;
         oWR_DROP <= dropNext;
         if (rdHit) begin
            oR <= ioSRAM_DQ[R_MSB:R_LSB];
            oG <= ioSRAM_DQ[G_MSB:G_LSB];
            oB <= ioSRAM_DQ[B_MSB:B_LSB];
         end else if (iREQ) begin
            oR <= '0;
            oG <= '0;
            oB <= '0;
         end
      end
   end

   assign oWR_FULL = fifoFull;

endmodule

// File: tb/tb_sram_pixel_server.sv
module tb_sram_pixel_server;

   logic        iCLK;
   logic        iRST_N;
   logic        iREQ;
   logic [9:0]  iX, iY;
   logic [4:0]  oR;
   logic [5:0]  oG;
   logic [4:0]  oB;
   logic        oREADY;
   logic        iWR_REQ;
   logic [9:0]  iWR_X, iWR_Y;
   logic [15:0] iWR_DATA;
   logic        oWR_FULL, oWR_DROP;
   logic [19:0] oSRAM_ADDR;
   wire  [15:0] ioSRAM_DQ;
   logic        oSRAM_CE_N, oSRAM_OE_N, oSRAM_WE_N, oSRAM_UB_N, oSRAM_LB_N;

   sram_pixel_server dut (
      .iCLK(iCLK), .iRST_N(iRST_N), .iREQ(iREQ), .iX(iX), .iY(iY),
      .oR(oR), .oG(oG), .oB(oB), .oREADY(oREADY),
      .iWR_REQ(iWR_REQ), .iWR_X(iWR_X), .iWR_Y(iWR_Y), .iWR_DATA(iWR_DATA),
      .oWR_FULL(oWR_FULL), .oWR_DROP(oWR_DROP),
      .oSRAM_ADDR(oSRAM_ADDR), .ioSRAM_DQ(ioSRAM_DQ),
      .oSRAM_CE_N(oSRAM_CE_N), .oSRAM_OE_N(oSRAM_OE_N), .oSRAM_WE_N(oSRAM_WE_N),
      .oSRAM_UB_N(oSRAM_UB_N), .oSRAM_LB_N(oSRAM_LB_N)
   );

   initial iCLK = 1'b0;
   always #5 iCLK = ~iCLK;

   // power-up SRAM contents; 1290 preset for the directed read-hit case
   function automatic logic [15:0] initWord(input int a);
      if (a == 1290) return 16'hF81F;
      return 16'(a * 40503 + 'h1234);
   endfunction

   // ---------------- SRAM device model ----------------
   bit [15:0] sramMem [0:1048575];
   bit        sramVld [0:1048575];
   logic      tbDqEn;
   logic [15:0] sramRd;
   assign sramRd = sramVld[oSRAM_ADDR] ? sramMem[oSRAM_ADDR] : initWord(32'(oSRAM_ADDR));
   assign ioSRAM_DQ = (!oSRAM_CE_N && !oSRAM_OE_N && oSRAM_WE_N) ? sramRd :
                      tbDqEn ? 16'hA5A5 : 16'hzzzz;
   always @(posedge iCLK) begin
      if (!oSRAM_CE_N && !oSRAM_WE_N) begin
         sramMem[oSRAM_ADDR] <= ioSRAM_DQ;
         sramVld[oSRAM_ADDR] <= 1'b1;
      end
   end

   // ---------------- reference model ----------------
   typedef struct { int addr; logic [15:0] data; } wr_t;
   wr_t         q[$];
   logic [15:0] pmap [int];
   logic [15:0] mPix;
   logic        mReady, mFull, mDrop;

   function automatic logic [15:0] pixelOf(input int a);
      return pmap.exists(a) ? pmap[a] : initWord(a);
   endfunction

   int nChecks = 0;
   int nFails  = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   logic        obsOe, obsWe;
   logic [19:0] obsAddr;

   // Called 1 time unit after a rising edge. Drives one cycle of inputs,
   // checks the combinational bus mid-cycle, then the registered outputs.
   task automatic runCycle(input logic req, input logic [9:0] x, input logic [9:0] y,
                           input logic wr, input logic [9:0] wx, input logic [9:0] wy,
                           input logic [15:0] wd);
      logic hit, pop;
      int   sizeBefore, ea;
      iREQ = req; iX = x; iY = y;
      iWR_REQ = wr; iWR_X = wx; iWR_Y = wy; iWR_DATA = wd;
      #3;
      hit = req && (x < 640) && (y < 480);
      sizeBefore = q.size();
      pop = !hit && (sizeBefore > 0);
      ea = hit ? int'(y) * 640 + int'(x) : (pop ? q[0].addr : 0);
      obsOe = oSRAM_OE_N; obsWe = oSRAM_WE_N; obsAddr = oSRAM_ADDR;
      chk("oe_n", 32'(oSRAM_OE_N), 32'(!hit));
      chk("we_n", 32'(oSRAM_WE_N), 32'(!pop));
      chk("addr", 32'(oSRAM_ADDR), 32'(ea));
      chk("ce_ub_lb", 32'({oSRAM_CE_N, oSRAM_UB_N, oSRAM_LB_N}), 32'(0));
      if (pop) chk("dq_wr", 32'(ioSRAM_DQ), 32'(q[0].data));
      if (hit) mPix = pixelOf(ea);
      else if (req) mPix = 16'h0;
      mReady = req;
      if (pop) begin
         pmap[q[0].addr] = q[0].data;
         void'(q.pop_front());
      end
      mDrop = 1'b0;
      if (wr && (wx < 640) && (wy < 480)) begin
         if (sizeBefore < 4 || pop) q.push_back('{int'(wy) * 640 + int'(wx), wd});
         else mDrop = 1'b1;
      end
      mFull = (q.size() == 4);
      @(posedge iCLK);
      #1;
      chk("ready", 32'(oREADY), 32'(mReady));
      chk("pixel", 32'({oR, oG, oB}), 32'(mPix));
      chk("full", 32'(oWR_FULL), 32'(mFull));
      chk("drop", 32'(oWR_DROP), 32'(mDrop));
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic req; logic [9:0] x, y;
      logic wr;  logic [9:0] wx, wy; logic [15:0] wd;
      logic eOe, eWe; logic [19:0] eAddr;
      logic eRdy; logic [15:0] ePix; logic eFull, eDrop;
   } vec_t;

   function automatic vec_t mv(input logic req, input int x, input int y,
                               input logic wr, input int wx, input int wy, input logic [15:0] wd,
                               input logic eOe, input logic eWe, input int eAddr,
                               input logic eRdy, input logic [15:0] ePix,
                               input logic eFull, input logic eDrop);
      vec_t v;
      v.req = req; v.x = 10'(x); v.y = 10'(y);
      v.wr = wr; v.wx = 10'(wx); v.wy = 10'(wy); v.wd = wd;
      v.eOe = eOe; v.eWe = eWe; v.eAddr = 20'(eAddr);
      v.eRdy = eRdy; v.ePix = ePix; v.eFull = eFull; v.eDrop = eDrop;
      return v;
   endfunction

   vec_t vecs[$];

   initial begin
      logic [15:0] p0, p5;
      logic [9:0]  rx, ry, wx, wy;
      p0 = initWord(0);
      p5 = initWord(5);
      //           req x   y   wr wx  wy  wd        oe we addr    rdy pix       full drop
      vecs.push_back(mv(1, 10, 2,   0, 0,  0,  16'h0,    0, 1, 1290,   1, 16'hF81F, 0, 0));
      vecs.push_back(mv(0, 0,  0,   0, 0,  0,  16'h0,    1, 1, 0,      0, 16'hF81F, 0, 0));
      vecs.push_back(mv(1, 640,0,   0, 0,  0,  16'h0,    1, 1, 0,      1, 16'h0000, 0, 0));
      vecs.push_back(mv(0, 0,  0,   1, 639,479,16'h07E0, 1, 1, 0,      0, 16'h0000, 0, 0));
      vecs.push_back(mv(0, 0,  0,   0, 0,  0,  16'h0,    1, 0, 307199, 0, 16'h0000, 0, 0));
      vecs.push_back(mv(1, 639,479, 0, 0,  0,  16'h0,    0, 1, 307199, 1, 16'h07E0, 0, 0));
      vecs.push_back(mv(1, 0,  0,   1, 1,  0,  16'h1111, 0, 1, 0,      1, p0,       0, 0));
      vecs.push_back(mv(1, 0,  0,   1, 2,  0,  16'h2222, 0, 1, 0,      1, p0,       0, 0));
      vecs.push_back(mv(1, 0,  0,   1, 3,  0,  16'h3333, 0, 1, 0,      1, p0,       0, 0));
      vecs.push_back(mv(1, 0,  0,   1, 4,  0,  16'h4444, 0, 1, 0,      1, p0,       1, 0));
      vecs.push_back(mv(1, 0,  0,   1, 5,  0,  16'h5555, 0, 1, 0,      1, p0,       1, 1));
      vecs.push_back(mv(0, 0,  0,   1, 6,  0,  16'h6666, 1, 0, 1,      0, p0,       1, 0));
      vecs.push_back(mv(0, 0,  0,   0, 0,  0,  16'h0,    1, 0, 2,      0, p0,       0, 0));
      vecs.push_back(mv(0, 0,  0,   0, 0,  0,  16'h0,    1, 0, 3,      0, p0,       0, 0));
      vecs.push_back(mv(0, 0,  0,   0, 0,  0,  16'h0,    1, 0, 4,      0, p0,       0, 0));
      vecs.push_back(mv(0, 0,  0,   0, 0,  0,  16'h0,    1, 0, 6,      0, p0,       0, 0));
      vecs.push_back(mv(0, 0,  0,   0, 0,  0,  16'h0,    1, 1, 0,      0, p0,       0, 0));
      vecs.push_back(mv(1, 2,  0,   0, 0,  0,  16'h0,    0, 1, 2,      1, 16'h2222, 0, 0));
      vecs.push_back(mv(1, 5,  0,   0, 0,  0,  16'h0,    0, 1, 5,      1, p5,       0, 0));
      vecs.push_back(mv(1, 6,  0,   0, 0,  0,  16'h0,    0, 1, 6,      1, 16'h6666, 0, 0));
      vecs.push_back(mv(1, 639,480, 0, 0,  0,  16'h0,    1, 1, 0,      1, 16'h0000, 0, 0));
      vecs.push_back(mv(0, 0,  0,   1, 0,  480,16'hBEEF, 1, 1, 0,      0, 16'h0000, 0, 0));
      vecs.push_back(mv(0, 0,  0,   0, 0,  0,  16'h0,    1, 1, 0,      0, 16'h0000, 0, 0));

      tbDqEn = 1'b0;
      iRST_N = 1'b0;
      iREQ = 0; iX = 0; iY = 0; iWR_REQ = 0; iWR_X = 0; iWR_Y = 0; iWR_DATA = 0;
      mPix = 0; mReady = 0; mFull = 0; mDrop = 0;
      #2;
      chk("rst_strobes", 32'({oSRAM_CE_N, oSRAM_OE_N, oSRAM_WE_N}), 32'(3'b111));
      chk("rst_addr", 32'(oSRAM_ADDR), 32'(0));
      chk("rst_outs", 32'({oR, oG, oB, oREADY, oWR_FULL, oWR_DROP}), 32'(0));
      repeat (2) @(posedge iCLK);
      #1;
      iRST_N = 1'b1;

      foreach (vecs[i]) begin
         runCycle(vecs[i].req, vecs[i].x, vecs[i].y, vecs[i].wr, vecs[i].wx, vecs[i].wy, vecs[i].wd);
         chk($sformatf("tbl%0d_oe", i), 32'(obsOe), 32'(vecs[i].eOe));
         chk($sformatf("tbl%0d_we", i), 32'(obsWe), 32'(vecs[i].eWe));
         chk($sformatf("tbl%0d_addr", i), 32'(obsAddr), 32'(vecs[i].eAddr));
         chk($sformatf("tbl%0d_ready", i), 32'(oREADY), 32'(vecs[i].eRdy));
         chk($sformatf("tbl%0d_pix", i), 32'({oR, oG, oB}), 32'(vecs[i].ePix));
         chk($sformatf("tbl%0d_full", i), 32'(oWR_FULL), 32'(vecs[i].eFull));
         chk($sformatf("tbl%0d_drop", i), 32'(oWR_DROP), 32'(vecs[i].eDrop));
      end

      // reset in the middle of a drain: queued writes are lost
      runCycle(1, 10'd0, 10'd0, 1, 10'd7, 10'd1, 16'hABCD);
      runCycle(1, 10'd0, 10'd0, 1, 10'd8, 10'd1, 16'hBCDE);
      iREQ = 0; iWR_REQ = 0;
      #3;
      chk("pre_rst_we", 32'(oSRAM_WE_N), 32'(0));
      chk("pre_rst_addr", 32'(oSRAM_ADDR), 32'(647));
      iRST_N = 1'b0;
      tbDqEn = 1'b1;
      #1;
      chk("mid_rst_strobes", 32'({oSRAM_CE_N, oSRAM_OE_N, oSRAM_WE_N}), 32'(3'b111));
      chk("mid_rst_addr", 32'(oSRAM_ADDR), 32'(0));
      chk("mid_rst_dq_free", 32'(ioSRAM_DQ), 32'(16'hA5A5));
      chk("mid_rst_outs", 32'({oR, oG, oB, oREADY, oWR_FULL, oWR_DROP}), 32'(0));
      tbDqEn = 1'b0;
      q.delete();
      mPix = 0; mReady = 0; mFull = 0; mDrop = 0;
      repeat (2) @(posedge iCLK);
      #1;
      iRST_N = 1'b1;
      runCycle(0, 10'd0, 10'd0, 0, 10'd0, 10'd0, 16'h0);
      chk("post_rst_full", 32'(oWR_FULL), 32'(0));
      runCycle(1, 10'd7, 10'd1, 0, 10'd0, 10'd0, 16'h0);
      chk("post_rst_lost", 32'({oR, oG, oB}), 32'(initWord(647)));

      // randomized traffic on a small pixel window to force read/write collisions
      for (int n = 0; n < 600; n++) begin
         rx = ($urandom_range(0, 11) == 0) ? 10'($urandom_range(630, 1023)) : 10'($urandom_range(0, 7));
         ry = ($urandom_range(0, 11) == 0) ? 10'($urandom_range(470, 1023)) : 10'($urandom_range(0, 3));
         wx = ($urandom_range(0, 11) == 0) ? 10'($urandom_range(630, 1023)) : 10'($urandom_range(0, 7));
         wy = ($urandom_range(0, 11) == 0) ? 10'($urandom_range(470, 1023)) : 10'($urandom_range(0, 3));
         runCycle(($urandom_range(0, 99) < 55), rx, ry,
                  ($urandom_range(0, 99) < 50), wx, wy, 16'($urandom));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
